// File: rtl/ptp_pkg.sv
// Shared constants and FSM encoding for the PTP transmit generator.
package ptp_pkg;

  localparam logic [3:0]  PTP_SYNC        = 4'd1;
  localparam logic [3:0]  PTP_DREQ        = 4'd3;
  localparam logic [3:0]  PTP_DRESQ       = 4'd4;
  localparam logic [15:0] PTP_ETHERTYPE   = 16'h88F7;
  localparam logic [7:0]  PTP_VERSION     = 8'h02;
  localparam int          PTP_FRAME_BEATS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } tx_state_t;

endpackage

// File: rtl/ptp_sync_timer.sv
// Sync period counter: counts 0..PERIOD-1 while enabled, held at 0 otherwise.
// wrap pulses for one cycle in the last count of each period.
module ptp_sync_timer
  import ptp_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'd125000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic wrap
);

  logic [31:0] cnt;

  assign wrap = en && (cnt == PERIOD - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ptp_tx_gen.sv
// PTP transmit generator: sync/delay-req/delay-resp requests become 8-beat frames on a valid/ready stream.
// Per-type frame counters are built only when PTP_TX_STATS_EN is defined.
module ptp_tx_gen
  import ptp_pkg::*;
#(
  parameter logic [31:0] SYNC_PERIOD = 32'd125000,
  parameter logic [47:0] DST_MAC     = 48'h011B19000000,
  parameter logic [47:0] SRC_MAC     = 48'h000A35000001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_or_s,
  input  logic        sync_en,
  input  logic        send_dreq_pkt,
  input  logic        send_dresq_pkt,
  input  logic [63:0] resp_ts,
  input  logic [63:0] local_time,
  output logic [63:0] pkt_data,
  output logic        pkt_valid,
  output logic        pkt_sop,
  output logic        pkt_eop,
  input  logic        pkt_ready,
  output logic [3:0]  ptp_send_type,
  output logic        ptp_send_type_valid,
  output logic [63:0] tx_ts,
  output logic [15:0] drop_cnt,
  output logic [31:0] stat_sync_cnt,
  output logic [31:0] stat_dreq_cnt,
  output logic [31:0] stat_dresq_cnt
);

  localparam logic [2:0] LAST_BEAT = 3'(PTP_FRAME_BEATS - 1);

  tx_state_t   state;
  logic        sync_wrap;
  logic        pend_sync, pend_dreq, pend_dresq;
  logic [63:0] resp_ts_q, frame_resp, tx_ts_q;
  logic [3:0]  cur_type, sel_type;
  logic [15:0] cur_seq, sel_seq;
  logic [15:0] seq_sync, seq_dreq, seq_dresq;
  logic [2:0]  beat;
  logic        take, clr_sync, clr_dreq, clr_dresq;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  ptp_sync_timer #(.PERIOD(SYNC_PERIOD)) u_sync_timer (
    .clk   (clk),
    .reset (reset),
    .en    (m_or_s && sync_en),
    .wrap  (sync_wrap)
  );

  assign take      = (state == ST_IDLE) && (pend_sync || pend_dreq || pend_dresq);
  assign clr_dresq = take && pend_dresq;
  assign clr_dreq  = take && pend_dreq && !pend_dresq;
  assign clr_sync  = take && pend_sync && !pend_dreq && !pend_dresq;

  // A request only counts as lost if its flag is set and not being consumed this cycle.
  assign drop_inc = {1'b0, sync_wrap && pend_sync && !clr_sync}
                  + {1'b0, send_dreq_pkt && pend_dreq && !clr_dreq}
                  + {1'b0, send_dresq_pkt && pend_dresq && !clr_dresq};
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);

  always_comb begin
    sel_type = PTP_SYNC;
    sel_seq  = seq_sync;
    if (pend_dresq) begin
      sel_type = PTP_DRESQ;
      sel_seq  = seq_dresq;
    end else if (pend_dreq) begin
      sel_type = PTP_DREQ;
      sel_seq  = seq_dreq;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_sync  <= 1'b0;
      pend_dreq  <= 1'b0;
      pend_dresq <= 1'b0;
      resp_ts_q  <= '0;
      drop_cnt   <= '0;
    end else begin
      pend_sync  <= sync_wrap || (pend_sync && !clr_sync);
      pend_dreq  <= send_dreq_pkt || (pend_dreq && !clr_dreq);
      pend_dresq <= send_dresq_pkt || (pend_dresq && !clr_dresq);
      if (send_dresq_pkt && !(pend_dresq && !clr_dresq)) begin
        resp_ts_q <= resp_ts;
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      beat                <= '0;
      cur_type            <= '0;
      cur_seq             <= '0;
      frame_resp          <= '0;
      tx_ts_q             <= '0;
      seq_sync            <= '0;
      seq_dreq            <= '0;
      seq_dresq           <= '0;
      ptp_send_type       <= '0;
      ptp_send_type_valid <= 1'b0;
      tx_ts               <= '0;
    end else begin
      ptp_send_type_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            cur_type   <= sel_type;
            cur_seq    <= sel_seq;
            frame_resp <= resp_ts_q;
            beat       <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (pkt_ready) begin
            if (beat == 3'd0) tx_ts_q <= local_time;
            beat <= beat + 3'd1;
            if (beat == LAST_BEAT) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          ptp_send_type_valid <= 1'b1;
          ptp_send_type       <= cur_type;
          tx_ts               <= tx_ts_q;
          case (cur_type)
            PTP_DRESQ: seq_dresq <= seq_dresq + 16'd1;
            PTP_DREQ:  seq_dreq  <= seq_dreq + 16'd1;
            default:   seq_sync  <= seq_sync + 16'd1;
          endcase
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_valid = (state == ST_SEND);
  assign pkt_sop   = pkt_valid && (beat == 3'd0);
  assign pkt_eop   = pkt_valid && (beat == LAST_BEAT);

  always_comb begin
    pkt_data = '0;
    if (pkt_valid) begin
      case (beat)
        3'd0:    pkt_data = {DST_MAC, SRC_MAC[47:32]};
        3'd1:    pkt_data = {SRC_MAC[31:0], PTP_ETHERTYPE, 4'h0, cur_type, PTP_VERSION};
        3'd2:    pkt_data = {cur_seq, 48'h0};
        3'd3:    pkt_data = tx_ts_q;
        3'd4:    pkt_data = (cur_type == PTP_DRESQ) ? frame_resp : 64'h0;
        default: pkt_data = '0;
      endcase
    end
  end

`ifdef PTP_TX_STATS_EN
  logic [31:0] st_sync, st_dreq, st_dresq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_sync  <= '0;
      st_dreq  <= '0;
      st_dresq <= '0;
    end else if (state == ST_DONE) begin
      case (cur_type)
        PTP_DRESQ: st_dresq <= st_dresq + 32'd1;
        PTP_DREQ:  st_dreq  <= st_dreq + 32'd1;
        default:   st_sync  <= st_sync + 32'd1;
      endcase
    end
  end

  assign stat_sync_cnt  = st_sync;
  assign stat_dreq_cnt  = st_dreq;
  assign stat_dresq_cnt = st_dresq;
`else
  assign stat_sync_cnt  = 32'h0;
  assign stat_dreq_cnt  = 32'h0;
  assign stat_dresq_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ptp_tx_gen.sv
// Bench for ptp_tx_gen: transaction-level monitor plus a frame/sequence model derived from the frame format.
module tb_ptp_tx_gen;

  localparam logic [47:0] DST = 48'h011B19000000;
  localparam logic [47:0] SRC = 48'h000A35000001;

  logic        clk = 1'b0, reset = 1'b0;
  logic        m_or_s = 1'b0, sync_en = 1'b0;
  logic        send_dreq_pkt = 1'b0, send_dresq_pkt = 1'b0;
  logic [63:0] resp_ts = '0;
  logic [63:0] local_time = 64'h0000_1000_0000_0000;
  logic        pkt_ready = 1'b0;
  logic [63:0] pkt_data, tx_ts;
  logic        pkt_valid, pkt_sop, pkt_eop, ptp_send_type_valid;
  logic [3:0]  ptp_send_type;
  logic [15:0] drop_cnt;
  logic [31:0] stat_sync_cnt, stat_dreq_cnt, stat_dresq_cnt;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int seq_m[3];
  int drop_m = 0;

  ptp_tx_gen #(.SYNC_PERIOD(32'd16)) dut (
    .clk(clk), .reset(reset), .m_or_s(m_or_s), .sync_en(sync_en),
    .send_dreq_pkt(send_dreq_pkt), .send_dresq_pkt(send_dresq_pkt),
    .resp_ts(resp_ts), .local_time(local_time),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
    .pkt_ready(pkt_ready), .ptp_send_type(ptp_send_type),
    .ptp_send_type_valid(ptp_send_type_valid), .tx_ts(tx_ts), .drop_cnt(drop_cnt),
    .stat_sync_cnt(stat_sync_cnt), .stat_dreq_cnt(stat_dreq_cnt), .stat_dresq_cnt(stat_dresq_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    local_time = local_time + 64'd1 + 64'($urandom_range(0, 3));
  end

  typedef struct { logic [7:0][63:0] b; logic [63:0] ts0; bit ok; int c0; int c7; } frame_t;
  typedef struct { logic [3:0] t; logic [63:0] ts; int c; } strobe_t;
  frame_t  frames[$];
  strobe_t strobes[$];
  frame_t  cur;
  int      mbeat = 0;

  // Stream monitor: assembles accepted beats into frames, discarding partial frames on reset.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      mbeat = 0;
    end else begin
      if (pkt_valid && pkt_ready) begin
        if (mbeat == 0) begin cur.ok = 1; cur.ts0 = local_time; cur.c0 = cyc; end
        if (pkt_sop !== (mbeat == 0) || pkt_eop !== (mbeat == 7)) cur.ok = 0;
        cur.b[mbeat] = pkt_data;
        if (mbeat == 7) begin cur.c7 = cyc; frames.push_back(cur); mbeat = 0; end
        else mbeat++;
      end
      if (ptp_send_type_valid) strobes.push_back('{ptp_send_type, tx_ts, cyc});
    end
  end

  function automatic logic [63:0] exp_beat(int i, logic [3:0] t, logic [15:0] s,
                                           logic [63:0] ts, logic [63:0] r);
    case (i)
      0:       return {DST, SRC[47:32]};
      1:       return {SRC[31:0], 16'h88F7, 4'h0, t, 8'h02};
      2:       return {s, 48'h0};
      3:       return ts;
      4:       return (t == 4'd4) ? r : 64'h0;
      default: return 64'h0;
    endcase
  endfunction

  function automatic int tidx(logic [3:0] t);
    return (t == 4'd1) ? 0 : (t == 4'd3) ? 1 : 2;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", pkt_valid); end
    n_cmp++; if ({pkt_sop, pkt_eop} !== 2'b00) begin n_bad++; $display("FAIL rst_sop_eop got %b want 00", {pkt_sop, pkt_eop}); end
    n_cmp++; if (pkt_data !== 64'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", pkt_data); end
    n_cmp++; if ({ptp_send_type_valid, ptp_send_type} !== 5'h0) begin n_bad++; $display("FAIL rst_type got %h want 0", {ptp_send_type_valid, ptp_send_type}); end
    n_cmp++; if (tx_ts !== 64'h0) begin n_bad++; $display("FAIL rst_tx_ts got %h want 0", tx_ts); end
    n_cmp++; if (drop_cnt !== 16'h0) begin n_bad++; $display("FAIL rst_drop got %h want 0", drop_cnt); end
    n_cmp++; if ({stat_sync_cnt, stat_dreq_cnt, stat_dresq_cnt} !== 96'h0) begin n_bad++; $display("FAIL rst_stats got %h want 0", {stat_sync_cnt, stat_dreq_cnt, stat_dresq_cnt}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_dreq();
    int pc;
    frames.delete(); strobes.delete();
    m_or_s = 1'b0; pkt_ready = 1'b1;
    send_dreq_pkt = 1'b1; pc = cyc; tick(); send_dreq_pkt = 1'b0;
    for (int k = 0; k < 60 && strobes.size() < 1; k++) tick();
    repeat (5) tick();
    n_cmp++; if (frames.size() != 1 || strobes.size() != 1) begin n_bad++; $display("FAIL dreq_count got %0d/%0d want 1/1", frames.size(), strobes.size()); end
    if (frames.size() >= 1 && strobes.size() >= 1) begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (frames[0].b[i] !== exp_beat(i, 4'd3, 16'(seq_m[1]), frames[0].ts0, 64'h0)) begin
          n_bad++; $display("FAIL dreq_beat%0d got %h want %h", i, frames[0].b[i], exp_beat(i, 4'd3, 16'(seq_m[1]), frames[0].ts0, 64'h0));
        end
      end
      n_cmp++; if (!frames[0].ok) begin n_bad++; $display("FAIL dreq_sop_eop got bad want sop@0 eop@7"); end
      n_cmp++; if (frames[0].c0 != pc + 2) begin n_bad++; $display("FAIL dreq_first_lat got %0d want %0d", frames[0].c0 - pc, 2); end
      n_cmp++; if (strobes[0].c != pc + 11) begin n_bad++; $display("FAIL dreq_strobe_lat got %0d want %0d", strobes[0].c - pc, 11); end
      n_cmp++; if (strobes[0].t !== 4'd3) begin n_bad++; $display("FAIL dreq_type got %0d want 3", strobes[0].t); end
      n_cmp++; if (strobes[0].ts !== frames[0].ts0) begin n_bad++; $display("FAIL dreq_tx_ts got %h want %h", strobes[0].ts, frames[0].ts0); end
    end
    seq_m[1]++;
  endtask

  task automatic test_dresq();
    logic [63:0] r;
    for (int it = 0; it < 2; it++) begin
      frames.delete(); strobes.delete();
      r = (it == 0) ? 64'h1122334455667788 : {$urandom, $urandom};
      resp_ts = r; send_dresq_pkt = 1'b1; tick();
      send_dresq_pkt = 1'b0; resp_ts = {$urandom, $urandom};
      for (int k = 0; k < 60 && strobes.size() < 1; k++) tick();
      n_cmp++; if (frames.size() != 1 || strobes.size() != 1) begin n_bad++; $display("FAIL dresq_count got %0d/%0d want 1/1", frames.size(), strobes.size()); end
      if (frames.size() >= 1 && strobes.size() >= 1) begin
        n_cmp++; if (frames[0].b[4] !== r) begin n_bad++; $display("FAIL dresq_beat4 got %h want %h", frames[0].b[4], r); end
        n_cmp++; if (frames[0].b[2] !== {16'(seq_m[2]), 48'h0}) begin n_bad++; $display("FAIL dresq_seq got %h want %h", frames[0].b[2], {16'(seq_m[2]), 48'h0}); end
        n_cmp++; if (frames[0].b[1] !== exp_beat(1, 4'd4, 16'h0, 64'h0, 64'h0)) begin n_bad++; $display("FAIL dresq_beat1 got %h want %h", frames[0].b[1], exp_beat(1, 4'd4, 16'h0, 64'h0, 64'h0)); end
        n_cmp++; if (strobes[0].ts !== frames[0].ts0) begin n_bad++; $display("FAIL dresq_tx_ts got %h want %h", strobes[0].ts, frames[0].ts0); end
        n_cmp++; if (frames[0].b[3] !== frames[0].ts0) begin n_bad++; $display("FAIL dresq_beat3 got %h want %h", frames[0].b[3], frames[0].ts0); end
        n_cmp++; if (strobes[0].t !== 4'd4) begin n_bad++; $display("FAIL dresq_type got %0d want 4", strobes[0].t); end
      end
      seq_m[2]++;
      repeat (3) tick();
    end
  endtask

  task automatic test_sync();
    int e;
    frames.delete(); strobes.delete();
    m_or_s = 1'b1; sync_en = 1'b1; pkt_ready = 1'b1; e = cyc;
    repeat (100) tick();
    sync_en = 1'b0;
    repeat (30) tick();
    n_cmp++; if (strobes.size() != 6 || frames.size() != 6) begin n_bad++; $display("FAIL sync_count got %0d/%0d want 6/6", strobes.size(), frames.size()); end
    for (int k = 0; k < 6 && k < strobes.size() && k < frames.size(); k++) begin
      n_cmp++; if (strobes[k].c != e + 26 + 16 * k) begin n_bad++; $display("FAIL sync_time%0d got %0d want %0d", k, strobes[k].c - e, 26 + 16 * k); end
      n_cmp++; if (strobes[k].t !== 4'd1) begin n_bad++; $display("FAIL sync_type%0d got %0d want 1", k, strobes[k].t); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (frames[k].b[i] !== exp_beat(i, 4'd1, 16'(seq_m[0]), frames[k].ts0, 64'h0)) begin
          n_bad++; $display("FAIL sync%0d_beat%0d got %h want %h", k, i, frames[k].b[i], exp_beat(i, 4'd1, 16'(seq_m[0]), frames[k].ts0, 64'h0));
        end
      end
      seq_m[0]++;
    end
    m_or_s = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0]  order[4];
    logic [63:0] r;
    logic [3:0]  t;
    order = '{4'd1, 4'd4, 4'd3, 4'd1};
    frames.delete(); strobes.delete();
    m_or_s = 1'b1; sync_en = 1'b1; pkt_ready = 1'b0;
    repeat (33) tick();
    sync_en = 1'b0; r = {$urandom, $urandom}; resp_ts = r;
    send_dreq_pkt = 1'b1; send_dresq_pkt = 1'b1; tick();
    send_dreq_pkt = 1'b0; send_dresq_pkt = 1'b0;
    repeat (2) tick();
    pkt_ready = 1'b1;
    for (int k = 0; k < 200 && strobes.size() < 4; k++) tick();
    n_cmp++; if (strobes.size() != 4 || frames.size() != 4) begin n_bad++; $display("FAIL prio_count got %0d/%0d want 4/4", strobes.size(), frames.size()); end
    for (int k = 0; k < 4 && k < strobes.size() && k < frames.size(); k++) begin
      t = order[k];
      n_cmp++; if (strobes[k].t !== t) begin n_bad++; $display("FAIL prio_type%0d got %0d want %0d", k, strobes[k].t, t); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (frames[k].b[i] !== exp_beat(i, t, 16'(seq_m[tidx(t)]), frames[k].ts0, r)) begin
          n_bad++; $display("FAIL prio%0d_beat%0d got %h want %h", k, i, frames[k].b[i], exp_beat(i, t, 16'(seq_m[tidx(t)]), frames[k].ts0, r));
        end
      end
      seq_m[tidx(t)]++;
    end
    n_cmp++; if (drop_cnt !== 16'(drop_m)) begin n_bad++; $display("FAIL prio_drop got %0d want %0d", drop_cnt, drop_m); end
    m_or_s = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic        stall_prev;
    logic [65:0] snap;
    frames.delete(); strobes.delete();
    stall_prev = 1'b0; snap = '0;
    for (int c = 0; c < 60; c++) begin
      send_dreq_pkt = (c == 0 || c == 5 || c == 9);
      pkt_ready = (c % 2 == 0);
      @(negedge clk);
      if (stall_prev) begin
        n_cmp++;
        if (pkt_valid !== 1'b1 || {pkt_sop, pkt_eop, pkt_data} !== snap) begin
          n_bad++; $display("FAIL bp_hold got v=%b %h want v=1 %h", pkt_valid, {pkt_sop, pkt_eop, pkt_data}, snap);
        end
      end
      stall_prev = pkt_valid && !pkt_ready;
      snap = {pkt_sop, pkt_eop, pkt_data};
      tick();
    end
    send_dreq_pkt = 1'b0; pkt_ready = 1'b1;
    drop_m++;
    for (int k = 0; k < 100 && strobes.size() < 2; k++) tick();
    repeat (15) tick();
    n_cmp++; if (strobes.size() != 2 || frames.size() != 2) begin n_bad++; $display("FAIL bp_count got %0d/%0d want 2/2", strobes.size(), frames.size()); end
    for (int k = 0; k < 2 && k < strobes.size() && k < frames.size(); k++) begin
      n_cmp++; if (strobes[k].t !== 4'd3) begin n_bad++; $display("FAIL bp_type%0d got %0d want 3", k, strobes[k].t); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (frames[k].b[i] !== exp_beat(i, 4'd3, 16'(seq_m[1]), frames[k].ts0, 64'h0)) begin
          n_bad++; $display("FAIL bp%0d_beat%0d got %h want %h", k, i, frames[k].b[i], exp_beat(i, 4'd3, 16'(seq_m[1]), frames[k].ts0, 64'h0));
        end
      end
      seq_m[1]++;
    end
    n_cmp++; if (drop_cnt !== 16'(drop_m)) begin n_bad++; $display("FAIL bp_drop got %0d want %0d", drop_cnt, drop_m); end
  endtask

  task automatic test_random();
    logic [3:0]  t;
    logic [63:0] r;
    for (int it = 0; it < 8; it++) begin
      frames.delete(); strobes.delete();
      t = ($urandom_range(0, 1) == 1) ? 4'd4 : 4'd3;
      r = {$urandom, $urandom};
      if (t == 4'd4) begin send_dresq_pkt = 1'b1; resp_ts = r; end
      else send_dreq_pkt = 1'b1;
      tick();
      send_dreq_pkt = 1'b0; send_dresq_pkt = 1'b0; resp_ts = {$urandom, $urandom};
      for (int k = 0; k < 300 && strobes.size() < 1; k++) begin
        pkt_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      pkt_ready = 1'b1;
      n_cmp++; if (strobes.size() != 1 || frames.size() != 1) begin n_bad++; $display("FAIL rnd%0d_count got %0d/%0d want 1/1", it, strobes.size(), frames.size()); end
      if (strobes.size() >= 1 && frames.size() >= 1) begin
        n_cmp++; if (strobes[0].t !== t || strobes[0].ts !== frames[0].ts0) begin n_bad++; $display("FAIL rnd%0d_strobe got %0d/%h want %0d/%h", it, strobes[0].t, strobes[0].ts, t, frames[0].ts0); end
        n_cmp++; if (!frames[0].ok) begin n_bad++; $display("FAIL rnd%0d_sop_eop got bad want sop@0 eop@7", it); end
        for (int i = 0; i < 8; i++) begin
          n_cmp++;
          if (frames[0].b[i] !== exp_beat(i, t, 16'(seq_m[tidx(t)]), frames[0].ts0, r)) begin
            n_bad++; $display("FAIL rnd%0d_beat%0d got %h want %h", it, i, frames[0].b[i], exp_beat(i, t, 16'(seq_m[tidx(t)]), frames[0].ts0, r));
          end
        end
      end
      seq_m[tidx(t)]++;
      repeat (3) tick();
    end
  endtask

  task automatic test_reset_midframe();
    frames.delete(); strobes.delete();
    pkt_ready = 1'b1;
    send_dreq_pkt = 1'b1; tick(); send_dreq_pkt = 1'b0;
    repeat (5) tick();
    #2;
    n_cmp++; if (pkt_valid !== 1'b1 || pkt_sop !== 1'b0) begin n_bad++; $display("FAIL mid_inflight got v=%b sop=%b want v=1 sop=0", pkt_valid, pkt_sop); end
    reset = 1'b0;
    #1;
    n_cmp++; if (pkt_valid !== 1'b0 || pkt_eop !== 1'b0) begin n_bad++; $display("FAIL mid_async_drop got v=%b eop=%b want 0/0", pkt_valid, pkt_eop); end
    repeat (3) tick();
    reset = 1'b1;
    seq_m = '{0, 0, 0}; drop_m = 0;
    repeat (20) tick();
    n_cmp++; if (frames.size() != 0 || strobes.size() != 0) begin n_bad++; $display("FAIL mid_aborted got %0d/%0d want 0/0", frames.size(), strobes.size()); end
    send_dreq_pkt = 1'b1; tick(); send_dreq_pkt = 1'b0;
    for (int k = 0; k < 60 && strobes.size() < 1; k++) tick();
    n_cmp++; if (frames.size() != 1 || strobes.size() != 1) begin n_bad++; $display("FAIL mid_fresh_count got %0d/%0d want 1/1", frames.size(), strobes.size()); end
    if (frames.size() >= 1) begin
      n_cmp++; if (frames[0].b[2] !== {16'(seq_m[1]), 48'h0}) begin n_bad++; $display("FAIL mid_fresh_seq got %h want %h", frames[0].b[2], {16'(seq_m[1]), 48'h0}); end
    end
    n_cmp++; if (drop_cnt !== 16'(drop_m)) begin n_bad++; $display("FAIL mid_drop got %0d want %0d", drop_cnt, drop_m); end
  endtask

  initial begin
    seq_m = '{0, 0, 0};
    test_reset();
    test_dreq();
    test_dresq();
    test_sync();
    test_priority();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
